// File: rtl/vectrex_load_pkg.sv
// rtl/vectrex_load_pkg.sv - shared state type and widths for the cartridge load sequencer
package vectrex_load_pkg;

  localparam int CART_ADDR_W = 15;
  localparam int HPS_ADDR_W  = 25;
  localparam int CNT_W       = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SKIP_WAIT = 2'd2,
    SKIP_RST  = 2'd3
  } state_t;

endpackage

// File: rtl/cart_load_ctrl_if.sv
// rtl/cart_load_ctrl_if.sv - HPS download / cart ROM signal bundle between hps_io and cart_load_ctrl
interface cart_load_ctrl_if #(
  parameter int ADDR_W = vectrex_load_pkg::CART_ADDR_W
);

  logic                                    ioctl_download;
  logic                                    ioctl_wr;
  logic [vectrex_load_pkg::HPS_ADDR_W-1:0] ioctl_addr;
  logic [7:0]                              ioctl_dout;
  logic                                    skip_logo;

  logic                                    cart_wr;
  logic [ADDR_W-1:0]                       cart_addr;
  logic [7:0]                              cart_data;
  logic [ADDR_W-1:0]                       cart_mask;
  logic                                    core_reset;
  logic                                    busy;
  logic                                    load_done;
  logic                                    size_err;

  // HPS side: drives the download, observes the cart ROM port
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, skip_logo,
    input  cart_wr, cart_addr, cart_data, cart_mask, core_reset, busy, load_done, size_err
  );

  // Sequencer side
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, skip_logo,
    output cart_wr, cart_addr, cart_data, cart_mask, core_reset, busy, load_done, size_err
  );

endinterface

// File: rtl/load_skip_timer.sv
// rtl/load_skip_timer.sv - down-counter timing the delayed skip-logo reset pulse
module load_skip_timer
  import vectrex_load_pkg::*;
#(
  parameter int SKIP_DELAY = 5000000,
  parameter int SKIP_PULSE = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic at_pulse,
  output logic at_zero
);

  logic [CNT_W-1:0] cnt;

  // Load at download end, count down while waiting/pulsing, stop at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SKIP_DELAY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign at_pulse = (cnt == CNT_W'(SKIP_PULSE));
  assign at_zero  = (cnt == '0);

endmodule

// File: rtl/cart_load_ctrl.sv
// rtl/cart_load_ctrl.sv - HPS cart download sequencer for the Vectrex core; SKIP_LOGO_EN builds the skip-logo reset pulse
module cart_load_ctrl
  import vectrex_load_pkg::*;
#(
  parameter int ADDR_W     = CART_ADDR_W,
  parameter int SKIP_DELAY = 5000000,
  parameter int SKIP_PULSE = 1000
) (
  input  logic            clk_sys,
  input  logic            reset,
  cart_load_ctrl_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic              dl_q;
  logic              rise;
  logic              fall;
  logic              wr_in_range;
  logic              cart_wr_q;
  logic [ADDR_W-1:0] cart_addr_q;
  logic [7:0]        cart_data_q;
  logic [ADDR_W-1:0] mask_q;
  logic              size_err_q;
  logic              load_done_q;
  logic              busy_c;
  logic              core_reset_c;

  assign rise        = bus.ioctl_download & ~dl_q;
  assign fall        = ~bus.ioctl_download & dl_q;
  assign wr_in_range = (bus.ioctl_addr[HPS_ADDR_W-1:ADDR_W] == '0);

`ifdef SKIP_LOGO_EN
  logic at_pulse;
  logic at_zero;

  load_skip_timer #(
    .SKIP_DELAY (SKIP_DELAY),
    .SKIP_PULSE (SKIP_PULSE)
  ) u_skip_timer (
    .clk      (clk_sys),
    .reset    (reset),
    .load     ((state == LOAD) && fall && bus.skip_logo),
    .clear    (rise),
    .dec      ((state == SKIP_WAIT) || (state == SKIP_RST)),
    .at_pulse (at_pulse),
    .at_zero  (at_zero)
  );
`else
  logic unused_skip;
  assign unused_skip = ^{bus.skip_logo, SKIP_DELAY, SKIP_PULSE};
`endif

  // State register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a new download restarts the sequence from any state
  always_comb begin
    state_nxt = state;
    if (rise) begin
      state_nxt = LOAD;
    end else begin
      case (state)
`ifdef SKIP_LOGO_EN
        LOAD:      if (fall) state_nxt = bus.skip_logo ? SKIP_WAIT : IDLE;
        SKIP_WAIT: if (at_pulse) state_nxt = SKIP_RST;
        SKIP_RST:  if (at_zero) state_nxt = IDLE;
`else
        LOAD:      if (fall) state_nxt = IDLE;
`endif
        default:   state_nxt = state;
      endcase
    end
  end

  // Outputs: core_reset follows download with no added latency; reset forces it low
  always_comb begin
    busy_c       = (state != IDLE);
`ifdef SKIP_LOGO_EN
    core_reset_c = ~reset & (bus.ioctl_download | (state == LOAD) | (state == SKIP_RST));
`else
    core_reset_c = ~reset & (bus.ioctl_download | (state == LOAD));
`endif
  end

  // Download edge tracking, cart write path, mask growth and status flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q        <= 1'b0;
      cart_wr_q   <= 1'b0;
      cart_addr_q <= '0;
      cart_data_q <= '0;
      mask_q      <= '0;
      size_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      dl_q        <= bus.ioctl_download;
      cart_wr_q   <= 1'b0;
      load_done_q <= ((state == LOAD) || (state == SKIP_RST)) && (state_nxt == IDLE);
      if (rise) begin
        mask_q     <= '0;
        size_err_q <= 1'b0;
      end else if ((state == LOAD) && bus.ioctl_wr) begin
        if (wr_in_range) begin
          cart_wr_q   <= 1'b1;
          cart_addr_q <= bus.ioctl_addr[ADDR_W-1:0];
          cart_data_q <= bus.ioctl_dout;
          // Grow by one bit per write; sequential loads reach the covering 2^k-1
          if ((bus.ioctl_addr[ADDR_W-1:0] & ~mask_q) != '0) begin
            mask_q <= {mask_q[ADDR_W-2:0], 1'b1};
          end
        end else begin
          size_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cart_wr    = cart_wr_q;
  assign bus.cart_addr  = cart_addr_q;
  assign bus.cart_data  = cart_data_q;
  assign bus.cart_mask  = mask_q;
  assign bus.size_err   = size_err_q;
  assign bus.load_done  = load_done_q;
  assign bus.busy       = busy_c;
  assign bus.core_reset = core_reset_c;

endmodule

// File: tb/tb_cart_load_ctrl.sv
// tb/tb_cart_load_ctrl.sv - directed-vector bench for cart_load_ctrl
module tb_cart_load_ctrl;

  localparam int ADDR_W = 15;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  cart_load_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cart_load_ctrl #(
    .ADDR_W     (ADDR_W),
    .SKIP_DELAY (100),
    .SKIP_PULSE (10)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int nwr;
    int bad;
    int lo;
    int hi;

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.skip_logo      = 1'b0;

    // reset state
    #2 reset = 1'b1;
    tick(); tick();
    chk("rst_cart_wr",    bus.cart_wr,    0);
    chk("rst_cart_addr",  bus.cart_addr,  0);
    chk("rst_cart_mask",  bus.cart_mask,  0);
    chk("rst_core_reset", bus.core_reset, 0);
    chk("rst_busy",       bus.busy,       0);
    chk("rst_load_done",  bus.load_done,  0);
    reset = 1'b0;
    tick();

    // 1: 4096-byte load, one write every other cycle
    bus.ioctl_download = 1'b1;
    #1 chk("t1_core_reset_comb", bus.core_reset, 1);
    tick();
    chk("t1_busy", bus.busy, 1);
    nwr = 0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i ^ 32'h5A);
      tick();
      if (bus.cart_wr) nwr++;
      if (bus.cart_wr !== 1'b1 || bus.cart_addr !== 15'(i) || bus.cart_data !== 8'(i ^ 32'h5A)) bad++;
      bus.ioctl_wr = 1'b0;
      tick();
      if (bus.cart_wr !== 1'b0) begin
        nwr++;
        bad++;
      end
    end
    chk("t1_wr_count", nwr, 4096);
    chk("t1_wr_bad",   bad, 0);
    bus.ioctl_download = 1'b0;
    #1 chk("t1_core_reset_fall_cycle", bus.core_reset, 1);
    tick();
    chk("t1_load_done",  bus.load_done,  1);
    chk("t1_core_reset", bus.core_reset, 0);
    chk("t1_busy_end",   bus.busy,       0);
    chk("t1_mask",       bus.cart_mask,  15'h0FFF);
    tick();
    chk("t1_load_done_1cyc", bus.load_done, 0);
    chk("t1_mask_hold",      bus.cart_mask, 15'h0FFF);

    // 2: out-of-range write sets size_err and is dropped
    bus.ioctl_download = 1'b1;
    tick();
    chk("t2_mask_cleared", bus.cart_mask, 0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h5;
    bus.ioctl_dout = 8'hC3;
    tick();
    chk("t2_wr5",   bus.cart_wr,   1);
    chk("t2_mask1", bus.cart_mask, 1);
    bus.ioctl_addr = 25'h8000;
    bus.ioctl_dout = 8'h11;
    tick();
    chk("t2_oor_no_wr",   bus.cart_wr,   0);
    chk("t2_size_err",    bus.size_err,  1);
    chk("t2_addr_kept",   bus.cart_addr, 15'h5);
    chk("t2_mask_kept",   bus.cart_mask, 1);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    chk("t2_load_done", bus.load_done, 1);
    tick(); tick();
    chk("t2_size_err_sticky", bus.size_err, 1);

    // 6: write strobe with download low is ignored
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h7FFF;
    tick();
    chk("t6_no_wr",      bus.cart_wr,   0);
    chk("t6_mask_same",  bus.cart_mask, 1);
    bus.ioctl_wr = 1'b0;
    tick();
    chk("t6_no_wr2", bus.cart_wr, 0);

    // next rise clears size_err
    bus.ioctl_download = 1'b1;
    tick();
    chk("t2_size_err_cleared", bus.size_err, 0);
    bus.ioctl_download = 1'b0;
    tick();
    tick();

`ifdef SKIP_LOGO_EN
    // 3: skip-logo pulse 90 cycles low then 10 high
    bus.skip_logo      = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h3;
    tick();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    chk("t3_no_done_at_fall", bus.load_done, 0);
    chk("t3_busy_wait",       bus.busy,      1);
    lo = 0;
    while (bus.core_reset === 1'b0 && lo < 300) begin
      lo++;
      tick();
    end
    chk("t3_wait_len", lo, 90);
    hi = 0;
    while (bus.core_reset === 1'b1 && hi < 300) begin
      hi++;
      tick();
    end
    chk("t3_pulse_len", hi, 10);
    chk("t3_load_done", bus.load_done, 1);
    chk("t3_busy_end",  bus.busy,      0);

    // 4: new rise during SKIP_WAIT restarts the load
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h3;
    tick();
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    repeat (20) tick();
    chk("t4_in_wait", bus.core_reset, 0);
    chk("t4_mask_pre", bus.cart_mask, 1);
    bus.ioctl_download = 1'b1;
    tick();
    chk("t4_mask_cleared", bus.cart_mask,  0);
    chk("t4_core_reset",   bus.core_reset, 1);
    bus.skip_logo      = 1'b0;
    bus.ioctl_download = 1'b0;
    tick();
    chk("t4_load_done", bus.load_done, 1);
    hi = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus.core_reset !== 1'b0) hi++;
    end
    chk("t4_no_pulse", hi, 0);
`else
    // skip_logo has no effect without the skip feature
    bus.skip_logo      = 1'b1;
    bus.ioctl_download = 1'b1;
    tick();
    bus.ioctl_download = 1'b0;
    tick();
    chk("ns_load_done", bus.load_done, 1);
    chk("ns_busy",      bus.busy,      0);
    hi = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (bus.core_reset !== 1'b0) hi++;
    end
    chk("ns_no_pulse", hi, 0);
    bus.skip_logo = 1'b0;
`endif

    // 5: async reset mid-load after 10 writes
    bus.ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = 8'(i + 1);
      tick();
    end
    chk("t5_mask_pre",  bus.cart_mask, 15'h000F);
    chk("t5_addr_pre",  bus.cart_addr, 15'h9);
    bus.ioctl_addr = 25'h8000;
    tick();
    chk("t5_size_err_pre", bus.size_err, 1);
    bus.ioctl_addr = 25'hA;
    reset = 1'b1;
    #1;
    chk("t5_cart_wr",    bus.cart_wr,    0);
    chk("t5_cart_addr",  bus.cart_addr,  0);
    chk("t5_cart_data",  bus.cart_data,  0);
    chk("t5_mask",       bus.cart_mask,  0);
    chk("t5_size_err",   bus.size_err,   0);
    chk("t5_core_reset", bus.core_reset, 0);
    chk("t5_busy",       bus.busy,       0);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("t5_no_done",  bus.load_done, 0);
    chk("t5_idle",     bus.busy,      0);
    tick();
    chk("t5_no_done2", bus.load_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
